// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    // Opcode presented to decode when IF/ID is empty; control treats it as a no-op.
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // PC advance; a 16-bit add wraps naturally from 16'hFFFF to 16'h0000.
    function automatic logic [WORD_W-1:0] pcIncrement(input logic [WORD_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry holding register for an instruction word that arrives while decode is stalled.
module fetch_unit_skid
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o
);

    logic              valid_q;
    logic [WORD_W-1:0] data_q;

    // Capture a parked word on load; clear wins so a redirect or consume empties the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches,
// and holds the IF/ID pipeline register feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    output logic [3:0]  opcode,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         drop_q, drop_d;
    logic         halted_q, halted_d;
    logic [15:0]  if_instr_q, if_instr_d;
    logic [15:0]  if_pc_q, if_pc_d;
    logic         if_valid_q, if_valid_d;

    logic         skid_valid;
    logic [15:0]  skid_data;
    logic         skid_load;
    logic         skid_clear;

    logic         redirect;
    logic         outstanding;
    logic         resp_now;

    assign redirect    = branch | branch_ne;
    assign resp_now    = (state_q == ST_WAIT) && !skid_valid && imem_valid;
    // A request is in flight from the cycle it is driven until its response lands.
    assign outstanding = ((state_q == ST_FETCH) && req_q) ||
                         ((state_q == ST_WAIT) && !skid_valid);

    fetch_unit_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (imem_rdata),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // Next-state logic, priority halt > redirect > stall > normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = 1'b0;
        drop_d     = drop_q;
        halted_d   = halted_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (state_q != ST_HALTED) begin
            if (halt) begin
                state_d    = ST_HALTED;
                halted_d   = 1'b1;
                if_valid_d = 1'b0;
                drop_d     = 1'b0;
                skid_clear = 1'b1;
            end else if (redirect) begin
                pc_d       = branch_target;
                if_valid_d = 1'b0;
                skid_clear = 1'b1;
                if (outstanding && !resp_now) begin
                    drop_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    drop_d  = 1'b0;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
            end else if (state_q == ST_FETCH) begin
                if (req_q) begin
                    state_d = ST_WAIT;
                end else begin
                    req_d = pc_write;
                end
            end else if (drop_q) begin
                if (imem_valid) begin
                    drop_d  = 1'b0;
                    state_d = ST_FETCH;
                    req_d   = pc_write;
                end
            end else if (skid_valid) begin
                if (pc_write) begin
                    if_instr_d = skid_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pcIncrement(pc_q);
                    skid_clear = 1'b1;
                    state_d    = ST_FETCH;
                    req_d      = 1'b1;
                end
            end else if (imem_valid) begin
                if (pc_write) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pcIncrement(pc_q);
                    state_d    = ST_FETCH;
                    req_d      = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end
        end
    end

    // State and IF/ID registers; reset abandons any in-flight fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            drop_q     <= 1'b0;
            halted_q   <= 1'b0;
            if_instr_q <= 16'h0000;
            if_pc_q    <= 16'h0000;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign halted    = halted_q;
    assign opcode    = if_valid_q ? if_instr_q[15:12] : OP_NOP;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit CPU and the IF/ID pipeline register; it sits directly upstream of `control`. It owns the PC and issues word fetches to instruction memory over a valid/response handshake. It presents the fetched instruction and its 4-bit opcode to decode. It consumes `control`'s `pc_write`, `branch`, `branch_ne` and `halt` outputs to stall, redirect, or stop fetching.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: fetch request; the address is sampled by memory in any cycle where this is 1.
- `imem_addr` out 16: word address of the fetch (equals the PC).
- `imem_rdata` in 16: returned instruction word, valid only with `imem_valid`.
- `imem_valid` in 1: response strobe, ≥1 cycle after the request.
- `pc_write` in 1: 0 means stall; hold PC and IF/ID, and issue no new request.
- `branch`, `branch_ne` in 1: taken branch (BEQ/BNE already resolved by control).
- `branch_target` in 16: redirect PC, valid when `branch|branch_ne`.
- `halt` in 1: stop fetching permanently until reset.
- `if_instr` out 16: IF/ID instruction register.
- `if_pc` out 16: PC of `if_instr`.
- `if_valid` out 1: IF/ID holds a real instruction.
- `opcode` out 4: `if_instr[15:12]` when `if_valid`, else `` `OP_NOP``.
- `halted` out 1: fetch has stopped.

## Operation
- FSM with states:
  - `FETCH`: drive `imem_req=1` and `imem_addr=pc` for exactly one cycle, then go to `WAIT`.
  - `WAIT`: wait for `imem_valid`.
  - `HALTED`: terminal state.
- At most one request is outstanding. `imem_req` is never high in `WAIT` or `HALTED`.
- Response in `WAIT` with `pc_write=1`:
  - `if_instr<=imem_rdata`, `if_pc<=pc`, `if_valid<=1`, `pc<=pc+1`.
  - The PC wraps modulo 2^16, so 16'hFFFF → 16'h0000.
  - Next state is `FETCH`.
- Response in `WAIT` with `pc_write=0`: the word goes into a one-entry skid register (`skid_valid<=1`). IF/ID and the PC hold. The state stays in `WAIT`, with no new request.
- When `pc_write` returns to 1 with `skid_valid=1`:
  - the skid word moves into IF/ID and `pc<=pc+1`;
  - `skid_valid<=0`;
  - the next state is `FETCH`.
- Stall in `FETCH`: the request is suppressed (`imem_req=0`) while `pc_write=0`.
- Redirect (`branch|branch_ne`):
  - `pc<=branch_target`, `if_valid<=0`, skid cleared.
  - If a request is outstanding, set `drop<=1`; the next `imem_valid` is discarded and clears `drop`. Otherwise go to `FETCH` next cycle.
  - A response arriving in the same cycle as the redirect is discarded.
- Halt: state becomes `HALTED`, `halted=1`, `imem_req=0`, `if_valid<=0`.
  - Any outstanding response is ignored.
  - Only `rst_n=0` leaves `HALTED`.
- Priority within a cycle: reset > halt > redirect > stall > normal fetch.
- A redirect overrides a stall in the same cycle. The PC loads the target even with `pc_write=0`, because the branching instruction is leaving decode.

## Timing
- Reset values (applied on any edge with `rst_n=0`, including mid-operation, with no completion of an in-flight fetch):
  - `pc=RESET_PC`, `imem_addr=RESET_PC`, `imem_req=0`;
  - `if_instr=16'h0000`, `if_pc=16'h0000`, `if_valid=0`;
  - `opcode=`OP_NOP``, `halted=0`;
  - `skid_valid=0`, `drop=0`, state=`FETCH`.
- First `imem_req=1` occurs in the first cycle after `rst_n` is sampled high.
- With 1-cycle memory, the fetch latency is request cycle N, `imem_valid` in N+1, `if_valid` high from N+2, next request in N+2. Throughput is one instruction per 2 cycles.
- Redirect sampled in cycle N: `imem_addr=branch_target` with `imem_req=1` in N+1 if nothing is outstanding; otherwise in the cycle after the dropped response.
- `opcode` is combinational from the IF/ID register. All other outputs are registered.

## Structure
- `` `OP_NOP`` is added to `def_opcode.v`. It is an encoding that `control` decodes through its default (no-op) branch.
- FSM state encodings are local parameters.
- No sub-module is needed. The optional `fetch_skid` one-entry holding register may be factored out.

## Test plan
- Reset with 1-cycle memory returning 16'h1234 at 0, 16'h2345 at 1 → `imem_addr` 0 then 1; `if_instr` 16'h1234, `if_pc` 0, `opcode` 4'h1; then 16'h2345, `if_pc` 1.
- `pc_write=0` for 3 cycles while the response for address 2 arrives → IF/ID and PC hold and no `imem_req` is seen. After release, the skid word appears in IF/ID one cycle later and `imem_addr=3` follows.
- `branch=1`, `branch_target=16'h0040` while a 3-cycle-latency fetch of address 5 is outstanding → the response for 5 is discarded, `if_valid=0`, and the next request is at 16'h0040.
- `halt=1` in a `WAIT` cycle → `halted=1` next cycle, no further `imem_req`, and a late `imem_valid` is ignored. `rst_n=0` restores a fetch at `RESET_PC`.
- PC at 16'hFFFF → after the fetch, the next `imem_addr` is 16'h0000.
- `rst_n=0` asserted in the same cycle as `imem_valid` → the response is ignored, `if_valid=0`, and the first fetch after release is at `RESET_PC`.
